// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
// cache_mem_arbiter
// Shares one pipelined main memory between the I-cache and D-cache miss
// handlers. A fill streams WORDS_PER_BLOCK sequential word reads for one
// block and steers the returned words to the owning cache. A D-cache store
// is a single-cycle write-through access.
// Optional build macro: ARB_ROUND_ROBIN_EN alternates contending fills
// between the two caches. D-cache stores always keep top priority.
module cache_mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_req,
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic                               d_req,
  input  logic                               d_wr,
  input  logic [ADDR_W-1:0]                  d_addr,
  input  logic [ADDR_W-1:0]                  d_wdata,
  output logic                               i_grant,
  output logic                               d_grant,
  output logic                               i_data_valid,
  output logic                               d_data_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_idx,
  output logic [ADDR_W-1:0]                  rdata,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               d_write_ack,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [ADDR_W-1:0]                  mem_wdata,
  input  logic [ADDR_W-1:0]                  mem_rdata,
  input  logic                               mem_rdata_valid
);

  localparam int                IDX_W    = $clog2(WORDS_PER_BLOCK);
  // Words are 2 bytes, so the block offset is one bit wider than the word index.
  localparam int                OFF_W    = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL_ISSUE, S_FILL_DRAIN, S_WRITE} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            pick;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  ret_cnt_q, ret_cnt_d;

  // State, owner, block base and the issue/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  // Next-state logic and all outputs; nothing reaches memory while idle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    word_idx     = '0;
    rdata        = '0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_write_ack  = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (d_req && d_wr) begin
          state_d = S_WRITE;
          owner_d = OWN_D;
        end else if (d_req || i_req) begin
          state_d     = S_FILL_ISSUE;
          owner_d     = pick;
          base_d      = ((pick == OWN_D) ? d_addr : i_addr) & ~OFF_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end

      S_FILL_ISSUE, S_FILL_DRAIN: begin
        i_grant = (owner_q == OWN_I);
        d_grant = (owner_q == OWN_D);
        if (state_q == S_FILL_ISSUE) begin
          mem_enable  = 1'b1;
          mem_addr    = base_q | ADDR_W'({issue_cnt_q, 1'b0});
          issue_cnt_d = issue_cnt_q + IDX_W'(1);
          if (issue_cnt_q == LAST_IDX) state_d = S_FILL_DRAIN;
        end
        // Returns may overlap issuing; the last return ends the fill.
        if (mem_rdata_valid) begin
          i_data_valid = (owner_q == OWN_I);
          d_data_valid = (owner_q == OWN_D);
          word_idx     = ret_cnt_q;
          rdata        = mem_rdata;
          ret_cnt_d    = ret_cnt_q + IDX_W'(1);
          if (ret_cnt_q == LAST_IDX) begin
            i_fill_done = (owner_q == OWN_I);
            d_fill_done = (owner_q == OWN_D);
            state_d     = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        d_grant     = 1'b1;
        d_write_ack = 1'b1;
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_addr;
        mem_wdata   = d_wdata;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q;
  logic   fill_start;

  // Contending fills go to whichever cache did not receive the previous fill.
  always_comb begin
    pick = d_req ? OWN_D : OWN_I;
    if (d_req && i_req) pick = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
  end

  assign fill_start = (state_q == S_IDLE) && !(d_req && d_wr) && (d_req || i_req);

  // Track the most recent fill owner; resetting to I lets D win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          last_owner_q <= OWN_I;
    else if (fill_start) last_owner_q <= pick;
  end
`else
  // Fixed priority: a pending D-cache fill always beats an I-cache fill.
  always_comb pick = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for cache_mem_arbiter: a fixed-latency memory responder, a
// transaction-level model compared against every output on every cycle,
// and directed scenarios with hand-computed addresses, cycles and orders.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic [2:0]  word_idx;
  logic [15:0] rdata;
  logic        i_fill_done, d_fill_done, d_write_ack;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdata_valid;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .word_idx(word_idx), .rdata(rdata),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_write_ack(d_write_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { int due; logic [15:0] data; } ret_t;
  ret_t rq[$];
  int   cyc   = 0;
  int   lat   = 4;
  logic stray = 1'b0;

  initial begin
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = rq[0].data;
        void'(rq.pop_front());
      end else if (stray) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = 16'hDEAD;
      end else begin
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  // m_kind: 0 idle, 1 block fill, 2 single write
  int          m_kind = 0;
  bit          m_own_d = 1'b0;
  logic [15:0] m_base = '0;
  int          m_iss = 0;
  int          m_ret = 0;
`ifdef ARB_ROUND_ROBIN_EN
  bit          m_last_d = 1'b0;
`endif

  logic        e_ig, e_dg, e_iv, e_dv, e_idone, e_ddone, e_wack, e_en, e_wr;
  logic [2:0]  e_idx;
  logic [15:0] e_rd, e_addr, e_wdata;

  // ---------------- observation logs ----------------
  logic [15:0] issue_log[$];
  int          issue_cyc[$];
  int          ret_idx[$];
  int          ret_cyc[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          wr_cyc[$];
  int          fill_order[$];  // 0 = I fill, 1 = D fill, in grant order
  int          i_done_n = 0, d_done_n = 0, w_ack_n = 0, i_valid_n = 0, d_valid_n = 0;
  int          i_grant_n = 0, i_done_cyc = 0, d_done_cyc = 0;
  logic        prev_ig = 1'b0, prev_dg = 1'b0;

  task automatic cmp_all();
    check("i_grant", i_grant, e_ig);
    check("d_grant", d_grant, e_dg);
    check("i_data_valid", i_data_valid, e_iv);
    check("d_data_valid", d_data_valid, e_dv);
    check("i_fill_done", i_fill_done, e_idone);
    check("d_fill_done", d_fill_done, e_ddone);
    check("d_write_ack", d_write_ack, e_wack);
    check("mem_enable", mem_enable, e_en);
    check("mem_wr", mem_wr, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    if (e_iv || e_dv) begin
      check("word_idx", word_idx, e_idx);
      check("rdata", rdata, e_rd);
    end
  endtask

  // Compare and log mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk) begin
    {e_ig, e_dg, e_iv, e_dv, e_idone, e_ddone, e_wack, e_en, e_wr} = '0;
    e_idx = '0; e_rd = '0; e_addr = '0; e_wdata = '0;
    if (!rst_n) begin
      cmp_all();
      check("rst_word_idx", word_idx, 0);
      check("rst_rdata", rdata, 0);
      m_kind = 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_d = 1'b0;
`endif
    end else begin
      if (m_kind == 1) begin
        e_ig = !m_own_d;
        e_dg = m_own_d;
        if (m_iss < 8) begin
          e_en   = 1'b1;
          e_addr = m_base + 16'(2 * m_iss);
        end
        if (mem_rdata_valid) begin
          e_iv  = !m_own_d;
          e_dv  = m_own_d;
          e_idx = 3'(m_ret);
          e_rd  = mem_fn(m_base + 16'(2 * m_ret));
          if (m_ret == 7) begin
            e_idone = !m_own_d;
            e_ddone = m_own_d;
          end
        end
      end else if (m_kind == 2) begin
        e_dg = 1'b1; e_wack = 1'b1; e_en = 1'b1; e_wr = 1'b1;
        e_addr = d_addr; e_wdata = d_wdata;
      end
      cmp_all();

      // advance the model to the next cycle
      if (m_kind == 0) begin
        if (d_req && d_wr) m_kind = 2;
        else if (d_req || i_req) begin
          m_own_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
          if (d_req && i_req) m_own_d = !m_last_d;
          m_last_d = m_own_d;
`endif
          m_base = (m_own_d ? d_addr : i_addr) & 16'hFFF0;
          m_iss  = 0;
          m_ret  = 0;
          m_kind = 1;
        end
      end else if (m_kind == 1) begin
        if (m_iss < 8) m_iss++;
        if (mem_rdata_valid) begin
          m_ret++;
          if (m_ret == 8) m_kind = 0;
        end
      end else begin
        m_kind = 0;
      end

      // record what the DUT actually did, and feed reads to the memory
      if (mem_enable && !mem_wr) begin
        ret_t r;
        r.due  = cyc + lat;
        r.data = mem_fn(mem_addr);
        rq.push_back(r);
        issue_log.push_back(mem_addr);
        issue_cyc.push_back(cyc);
      end
      if (mem_enable && mem_wr) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
        wr_cyc.push_back(cyc);
      end
      if (i_data_valid) i_valid_n++;
      if (d_data_valid) d_valid_n++;
      if (i_data_valid || d_data_valid) begin
        ret_idx.push_back(int'(word_idx));
        ret_cyc.push_back(cyc);
      end
      if (i_fill_done) begin i_done_n++; i_done_cyc = cyc; end
      if (d_fill_done) begin d_done_n++; d_done_cyc = cyc; end
      if (d_write_ack) w_ack_n++;
      if (i_grant) i_grant_n++;
      if (i_grant && !prev_ig) fill_order.push_back(0);
      if (d_grant && !prev_dg && !d_write_ack) fill_order.push_back(1);
    end
    prev_ig = rst_n && i_grant;
    prev_dg = rst_n && d_grant;
    cyc++;
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    issue_log.delete(); issue_cyc.delete(); ret_idx.delete(); ret_cyc.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc.delete(); fill_order.delete();
    i_grant_n = 0;
  endtask

  function automatic int count_of(input int which);
    case (which)
      0:       return i_done_n;
      1:       return d_done_n;
      2:       return w_ack_n;
      default: return i_valid_n;
    endcase
  endfunction

  // Wait (bounded) until a monitor counter reaches target, then step to the next cycle.
  task automatic wait_count(input int which, input int target, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (count_of(which) >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, ok, 1);
    @(posedge clk);
    #1;
  endtask

  // Lone I-fill at latency 4: issues t0+1..t0+8, returns t0+5..t0+12.
  task automatic ifill_scenario(input logic [15:0] addr, input logic [15:0] base, input string tag);
    int t0;
    clear_logs();
    lat    = 4;
    t0     = cyc;
    i_addr = addr;
    i_req  = 1'b1;
    wait_count(0, i_done_n + 1, tag);
    i_req = 1'b0;
    check({tag, "_issue_count"}, issue_log.size(), 8);
    for (int k = 0; k < 8 && k < issue_log.size(); k++) begin
      check({tag, "_issue_addr"}, issue_log[k], base + 16'(2 * k));
      check({tag, "_issue_cycle"}, issue_cyc[k], t0 + 1 + k);
    end
    check({tag, "_return_count"}, ret_idx.size(), 8);
    for (int k = 0; k < 8 && k < ret_idx.size(); k++) begin
      check({tag, "_word_idx"}, ret_idx[k], k);
      check({tag, "_return_cycle"}, ret_cyc[k], t0 + 5 + k);
    end
    check({tag, "_done_cycle"}, i_done_cyc, t0 + 12);
    check({tag, "_grant_cycles"}, i_grant_n, 12);
    check({tag, "_idle_grant"}, i_grant, 0);
    check({tag, "_idle_mem_enable"}, mem_enable, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, c0, vi, vd, i0, d0;
    int exp_order[4];
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_enable", mem_enable, 0);
    check("reset_i_grant", i_grant, 0);
    check("reset_mem_addr", mem_addr, 0);

    // I-fill right out of reset; the first post-reset cycle stays idle.
    rst_n = 1'b1;
    ifill_scenario(16'h1236, 16'h1230, "ifill");

    // D-cache write-through store.
    clear_logs();
    t0 = cyc;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    wait_count(2, w_ack_n + 1, "write");
    d_req = 1'b0; d_wr = 1'b0;
    check("write_count", wr_addr_log.size(), 1);
    if (wr_addr_log.size() > 0) begin
      check("write_addr", wr_addr_log[0], 16'h0040);
      check("write_data", wr_data_log[0], 16'hBEEF);
      check("write_cycle", wr_cyc[0], t0 + 1);
    end

    // Contention at latency 2: D fill first, one idle cycle, then the I fill.
    clear_logs();
    lat = 2;
    t0  = cyc;
    i_addr = 16'h2008; d_addr = 16'h345C;
    i_req = 1'b1; d_req = 1'b1;
    wait_count(1, d_done_n + 1, "contend_d");
    d_req = 1'b0;
    wait_count(0, i_done_n + 1, "contend_i");
    i_req = 1'b0;
    check("contend_order_len", fill_order.size(), 2);
    if (fill_order.size() == 2) begin
      check("contend_first", fill_order[0], 1);
      check("contend_second", fill_order[1], 0);
    end
    check("contend_d_done_cycle", d_done_cyc, t0 + 10);
    check("contend_i_done_cycle", i_done_cyc, t0 + 21);
    check("contend_issue_count", issue_log.size(), 16);
    if (issue_log.size() == 16) begin
      check("contend_d_base", issue_log[0], 16'h3450);
      check("contend_i_base", issue_log[8], 16'h2000);
      check("contend_gap", issue_cyc[8], t0 + 12);
    end

    // Both requesters stay pending until each has had two fills.
    clear_logs();
    i_addr = 16'h6000; d_addr = 16'h8010;
    i0 = i_done_n; d0 = d_done_n;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      i_req = (i_done_n - i0) < 2;
      d_req = (d_done_n - d0) < 2;
      if (!i_req && !d_req) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("repeat_fills_done", (i_done_n - i0) + (d_done_n - d0), 4);
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0};
`else
    exp_order = '{1, 1, 0, 0};
`endif
    check("repeat_order_len", fill_order.size(), 4);
    for (int k = 0; k < 4 && k < fill_order.size(); k++)
      check("repeat_order", fill_order[k], exp_order[k]);

    // Drop i_req after 3 returns and raise a D fill mid-fill (latency 3).
    clear_logs();
    lat = 3;
    t0  = cyc;
    i_addr = 16'h4444; i_req = 1'b1;
    wait_count(3, i_valid_n + 3, "drop_wait");
    i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7772;
    wait_count(0, i_done_n + 1, "drop_done");
    check("drop_returns", ret_idx.size(), 8);
    if (ret_idx.size() == 8) check("drop_last_idx", ret_idx[7], 7);
    check("drop_done_cycle", i_done_cyc, t0 + 11);
    check("drop_no_early_d", issue_log.size(), 8);
    wait_count(1, d_done_n + 1, "drop_d");
    d_req = 1'b0;
    if (issue_log.size() > 8) begin
      check("drop_d_base", issue_log[8], 16'h7770);
      check("drop_d_start", issue_cyc[8], t0 + 13);
    end
    check("drop_order_len", fill_order.size(), 2);

    // Stray valid while idle is ignored; the next fill starts at word 0.
    vi = i_valid_n; vd = d_valid_n;
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(posedge clk); #1;
    check("stray_i_valid", i_valid_n, vi);
    check("stray_d_valid", d_valid_n, vd);
    ifill_scenario(16'h1236, 16'h1230, "stray_ifill");

    // Reset in the middle of issuing; stale returns then land in idle.
    clear_logs();
    lat = 4;
    c0  = i_done_n;
    i_addr = 16'h5558; i_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_mem_enable", mem_enable, 1);
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    check("rst_mid_mem_enable", mem_enable, 0);
    check("rst_mid_i_grant", i_grant, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_i_valid", i_data_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", i_done_n, c0);
    ifill_scenario(16'h1236, 16'h1230, "post_rst_ifill");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
